eth_frame_loopback: RTL and testbench

Store-and-forward frame loopback stage placed between a QSFP CMAC RX AXI-Stream master and the TX AXI-Stream slave of the same port.
- Buffers each received frame in full before forwarding it.
- Drops frames flagged bad by the MAC, and frames that do not fit in the buffer.
- Swaps destination and source MAC addresses, so the link partner receives its own traffic addressed back to it.
- Provides saturating statistics counters.

---
 rtl/eth_frame_loopback.sv | 204 ++++++++++++++++++++
 tb/tb_eth_frame_loopback.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_loopback.sv
// Store-and-forward CMAC RX->TX loopback: drops bad/oversize frames, swaps dst/src MAC, counts outcomes.
// Latency: a frame's first beat is presented one cycle after its tlast is accepted (output register free).
// Backpressure: RX is never stalled (tready=1 out of reset); TX stalls hold m_axis stable, overflow drops frames.
module eth_frame_loopback #(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = 64,
    parameter int USER_WIDTH  = 17,
    parameter int DEPTH_BEATS = 64,
    parameter int SWAP_MAC    = 1
) (
    input  logic                  clk_161mhz_in,
    input  logic                  rst_161mhz_in,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [31:0]           stat_fwd_frames,
    output logic [31:0]           stat_err_drops,
    output logic [31:0]           stat_ovf_drops
);

    localparam int AW = $clog2(DEPTH_BEATS);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH_BEATS);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic                  tlast;
        logic [USER_WIDTH-2:0] tuser;
    } beat_t;

    typedef enum logic {
        WR_ACCEPT,
        WR_DROP
    } wr_state_t;

    beat_t     mem [DEPTH_BEATS];
    beat_t     wr_entry;
    beat_t     rd_entry;

    wr_state_t wr_state;
    wr_state_t wr_state_nxt;
    logic [AW:0] wr_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] commit_ptr;
    logic [AW:0] commit_ptr_nxt;
    logic [AW:0] rd_ptr;

    logic in_beat;
    logic full;
    logic wr_en;
    logic fwd_inc;
    logic err_inc;
    logic ovf_inc;

    logic avail;
    logic load;
    logic sof;
    logic swap_en;
    logic [DATA_WIDTH-1:0] out_data;

    // ---------------------------------------------------------------
    // Write side
    // ---------------------------------------------------------------
    assign s_axis_tready = ~rst_161mhz_in;
    assign in_beat       = s_axis_tvalid & s_axis_tready;
    assign full          = (wr_ptr - rd_ptr) == DEPTH_CNT;

    assign wr_entry.tdata = s_axis_tdata;
    assign wr_entry.tkeep = s_axis_tkeep;
    assign wr_entry.tlast = s_axis_tlast;
    assign wr_entry.tuser = s_axis_tuser[USER_WIDTH-1:1];

    always_comb begin
        wr_state_nxt   = wr_state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        wr_en          = 1'b0;
        fwd_inc        = 1'b0;
        err_inc        = 1'b0;
        ovf_inc        = 1'b0;
        if (in_beat) begin
            case (wr_state)
                WR_ACCEPT: begin
                    if (full) begin
                        // Roll back the partial frame; a full-on-tlast frame ends here.
                        wr_ptr_nxt = commit_ptr;
                        if (s_axis_tlast) begin
                            ovf_inc = 1'b1;
                        end else begin
                            wr_state_nxt = WR_DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        if (s_axis_tlast) begin
                            if (s_axis_tuser[0]) begin
                                wr_ptr_nxt = commit_ptr;
                                err_inc    = 1'b1;
                            end else begin
                                commit_ptr_nxt = wr_ptr + PTR_ONE;
                                fwd_inc        = 1'b1;
                            end
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) begin
                        ovf_inc      = 1'b1;
                        wr_state_nxt = WR_ACCEPT;
                    end
                end
                default: wr_state_nxt = WR_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk_161mhz_in or posedge rst_161mhz_in) begin
        if (rst_161mhz_in) begin
            wr_state   <= WR_ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            wr_state   <= wr_state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
        end
    end

    always_ff @(posedge clk_161mhz_in) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // ---------------------------------------------------------------
    // Read side
    // ---------------------------------------------------------------
    assign avail    = rd_ptr != commit_ptr;
    assign load     = avail & (~m_axis_tvalid | m_axis_tready);
    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign swap_en  = (SWAP_MAC != 0) & sof & (&rd_entry.tkeep[11:0]);

    always_comb begin
        out_data = rd_entry.tdata;
        if (swap_en) begin
            out_data[47:0]  = rd_entry.tdata[95:48];
            out_data[95:48] = rd_entry.tdata[47:0];
        end
    end

    always_ff @(posedge clk_161mhz_in or posedge rst_161mhz_in) begin
        if (rst_161mhz_in) begin
            rd_ptr        <= '0;
            sof           <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (load) begin
            rd_ptr        <= rd_ptr + PTR_ONE;
            sof           <= rd_entry.tlast;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= out_data;
            m_axis_tkeep  <= rd_entry.tkeep;
            m_axis_tlast  <= rd_entry.tlast;
            m_axis_tuser  <= {rd_entry.tuser, 1'b0};
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Saturating statistics
    // ---------------------------------------------------------------
    always_ff @(posedge clk_161mhz_in or posedge rst_161mhz_in) begin
        if (rst_161mhz_in) begin
            stat_fwd_frames <= '0;
            stat_err_drops  <= '0;
            stat_ovf_drops  <= '0;
        end else begin
            if (fwd_inc && stat_fwd_frames != '1) begin
                stat_fwd_frames <= stat_fwd_frames + 32'd1;
            end
            if (err_inc && stat_err_drops != '1) begin
                stat_err_drops <= stat_err_drops + 32'd1;
            end
            if (ovf_inc && stat_ovf_drops != '1) begin
                stat_ovf_drops <= stat_ovf_drops + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_loopback.sv
// Directed + randomized bench for eth_frame_loopback against a byte-level frame model and scoreboard.
module tb_eth_frame_loopback;

    localparam int DW    = 128;
    localparam int KW    = 16;
    localparam int UW    = 17;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } obeat_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic [31:0]   stat_fwd;
    logic [31:0]   stat_err;
    logic [31:0]   stat_ovf;

    eth_frame_loopback #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH_BEATS(DEPTH), .SWAP_MAC(1)
    ) dut (
        .clk_161mhz_in(clk),
        .rst_161mhz_in(rst),
        .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser),
        .stat_fwd_frames(stat_fwd),
        .stat_err_drops(stat_err),
        .stat_ovf_drops(stat_ovf)
    );

    int     vectors = 0;
    int     miscompares = 0;
    obeat_t exp_q[$];
    int     exp_fwd = 0;
    int     exp_err = 0;
    int     exp_ovf = 0;
    int     cyc = 0;
    int     last_hs = -10;
    int     run_len = 0;
    int     max_run = 0;
    bit     rand_rdy = 0;
    logic [DW-1:0] d0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk(tag, 256'({stat_fwd, stat_err, stat_ovf}),
            256'({32'(exp_fwd), 32'(exp_err), 32'(exp_ovf)}));
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW/32; w++) d[32*w +: 32] = $urandom;
        return d;
    endfunction

    // Output beat per the frame rules: MAC bytes 0-5 and 6-11 exchanged on the first beat if they are all valid.
    function automatic obeat_t model_out(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                         input bit last, input logic [UW-1:0] u, input bit first);
        obeat_t o;
        o.data = d;
        if (first && k[11:0] == 12'hFFF) begin
            for (int i = 0; i < 6; i++) begin
                o.data[8*i +: 8]     = d[8*(i+6) +: 8];
                o.data[8*(i+6) +: 8] = d[8*i +: 8];
            end
        end
        o.keep = k;
        o.last = last;
        o.user = {u[UW-1:1], 1'b0};
        return o;
    endfunction

    // fate: 0 = forwarded, 1 = error drop, 2 = overflow drop
    task automatic send_frame(input int len, input bit err, input int fate, input int gap_pct,
                              input bit partial, input bit fixed0, input logic [DW-1:0] fd,
                              input logic [UW-1:0] fu);
        obeat_t        tmp[$];
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [KW-1:0] all_k;
        logic [UW-1:0] u;
        bit            last;
        all_k = '1;
        for (int i = 0; i < len; i++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(99) < gap_pct) begin
                    s_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            d    = rand_data();
            u    = UW'($urandom);
            k    = all_k;
            last = (i == len - 1);
            if (i == 0 && fixed0) begin
                d = fd;
                u = fu;
            end
            if (last && len > 1) k = all_k >> $urandom_range(KW-1);
            if (i == 0 && partial) k = all_k >> $urandom_range(KW-1, 1);
            if (last) u[0] = err;
            s_tdata  = d;
            s_tkeep  = k;
            s_tlast  = last;
            s_tuser  = u;
            s_tvalid = 1'b1;
            @(posedge clk); #1;
            tmp.push_back(model_out(d, k, last, u, i == 0));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (fate == 0) begin
            foreach (tmp[j]) exp_q.push_back(tmp[j]);
            exp_fwd++;
        end else if (fate == 1) begin
            exp_err++;
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 256'({m_tvalid, 32'(exp_q.size())}), 256'(0));
    endtask

    // Output monitor: scoreboard compare on each handshake, stability check while stalled.
    initial begin
        obeat_t prev;
        obeat_t cur;
        bit     prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
                if (prev_stall) chk("hold_stable", 256'({m_tvalid, cur}), 256'({1'b1, prev}));
                if (m_tvalid && m_tready) begin
                    chk("beat_expected", 256'(exp_q.size() > 0), 256'(1));
                    if (exp_q.size() > 0) chk("out_beat", 256'(cur), 256'(exp_q.pop_front()));
                    run_len = (cyc == last_hs + 1) ? run_len + 1 : 1;
                    if (run_len > max_run) max_run = run_len;
                    last_hs = cyc;
                end
                prev_stall = m_tvalid && !m_tready;
                prev = cur;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) m_tready = 1'($urandom_range(1));
        end
    end

    initial begin
        rst = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_outputs", 256'({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, s_tready}), 256'(0));
        chk_stats("rst_stats");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("tready_after_rst", 256'(s_tready), 256'(1));

        // 1: single-beat frame, MAC swap and latency
        d0 = {32'hDEADBEEF, 48'hFFEEDDCCBBAA, 48'h665544332211};
        send_frame(1, 0, 0, 0, 0, 1, d0, 17'h00002);
        chk("t1_lat_edge_n", 256'(m_tvalid), 256'(0));
        @(posedge clk); #1;
        chk("t1_lat_edge_n1", 256'(m_tvalid), 256'(1));
        chk("t1_swapped_macs", 256'({m_tdata[95:0], m_tlast, m_tuser}),
            256'({48'h665544332211, 48'hFFEEDDCCBBAA, 1'b1, 17'h00002}));
        drain("t1_drain");
        chk_stats("t1_stats");

        // 2: errored frame then a good one
        send_frame(3, 1, 1, 0, 0, 0, '0, '0);
        send_frame(2, 0, 0, 0, 0, 0, '0, '0);
        drain("t2_drain");
        chk_stats("t2_stats");

        // 3: stalled TX, buffer fills, fifth frame overflows
        m_tready = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(4, 0, 0, 0, 0, 0, '0, '0);
        send_frame(4, 0, 2, 0, 0, 0, '0, '0);
        repeat (3) @(posedge clk); #1;
        chk("t3_stalled_valid", 256'(m_tvalid), 256'(1));
        chk_stats("t3_stats_stalled");
        m_tready = 1'b1;
        drain("t3_drain");

        // 4: ten back-to-back frames stream without bubbles
        repeat (5) @(posedge clk); #1;
        max_run = 0;
        for (int f = 0; f < 10; f++) send_frame(4, 0, 0, 0, 0, 0, '0, '0);
        drain("t4_drain");
        chk("t4_contiguous", 256'(max_run), 256'(40));
        chk_stats("t4_stats");

        // 5: frame longer than the buffer (error flag also set: overflow wins)
        send_frame(20, 1, 2, 0, 0, 0, '0, '0);
        send_frame(1, 0, 0, 0, 0, 0, '0, '0);
        drain("t5_drain");
        chk_stats("t5_stats");

        // randomized frames, gaps and TX backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int  n;
            int  len;
            bit  err;
            n = 0;
            while (exp_q.size() > 6 && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rand_throttle", 256'(exp_q.size() <= 6), 256'(1));
            len = $urandom_range(6, 1);
            err = ($urandom_range(3) == 0);
            send_frame(len, err, err ? 1 : 0, 30, (len == 1) && ($urandom_range(1) == 1), 0, '0, '0);
        end
        @(posedge clk); #1;
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        drain("rand_drain");
        chk_stats("rand_stats");

        // 6: reset mid-input-frame while a frame is mid-output
        m_tready = 1'b0;
        send_frame(4, 0, 0, 0, 0, 0, '0, '0);
        repeat (2) @(posedge clk); #1;
        chk("t6_mid_output", 256'(m_tvalid), 256'(1));
        for (int i = 0; i < 2; i++) begin
            s_tdata = rand_data(); s_tkeep = '1; s_tlast = 1'b0; s_tuser = '0; s_tvalid = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_immediate", 256'({m_tvalid, m_tdata, s_tready}), 256'(0));
        exp_q.delete();
        exp_fwd = 0; exp_err = 0; exp_ovf = 0;
        chk_stats("t6_rst_stats");
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("t6_no_remnant", 256'(m_tvalid), 256'(0));
        send_frame(1, 0, 0, 0, 0, 0, '0, '0);
        drain("t6_drain");
        chk_stats("t6_stats");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
